// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared opcodes, state/phase encodings and sizing helpers for
//               the SPI flash boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WAKE = 8'hAB;

    localparam int WAKE_BITS     = 8;
    localparam int READ_HDR_BITS = 32;
    localparam int WORD_BITS     = 16;

    // Sequencer states
    localparam logic [2:0] ST_WAKE_CMD  = 3'd0;
    localparam logic [2:0] ST_WAKE_GAP  = 3'd1;
    localparam logic [2:0] ST_READ_CMD  = 3'd2;
    localparam logic [2:0] ST_READ_DATA = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Bit engine phases
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_LOW  = 2'd1;
    localparam logic [1:0] PH_HIGH = 2'd2;
    localparam logic [1:0] PH_TAIL = 2'd3;

    // The read header and all data words go out as one unbroken burst.
    function automatic int read_bits(input int rom_size);
        return READ_HDR_BITS + WORD_BITS * rom_size;
    endfunction

    function automatic int addr_width(input int rom_size);
        return (rom_size > 1) ? $clog2(rom_size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_engine
// Description : SPI mode-0 SCK divider with MSB-first shifter and sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_engine
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] nbits,
    input  logic [31:0]      tx_data,
    input  logic             spi_miso,
    output logic             spi_sclk,
    output logic             spi_mosi,
    output logic             busy,
    output logic             bit_done,
    output logic             rx_bit,
    output logic             xfer_done
);

    localparam int              DIV_W      = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [1:0]       r_phase;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bits_left;
    logic [30:0]      r_shreg;
    logic             w_div_end;

    assign w_div_end = (r_div == C_DIV_LAST);
    assign busy      = (r_phase != PH_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_IDLE;
            r_div       <= '0;
            r_bits_left <= '0;
            r_shreg     <= '0;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
            bit_done    <= 1'b0;
            rx_bit      <= 1'b0;
            xfer_done   <= 1'b0;
        end else begin
            bit_done  <= 1'b0;
            xfer_done <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        r_shreg     <= tx_data[30:0];
                        spi_mosi    <= tx_data[31];
                        r_bits_left <= nbits;
                        r_div       <= '0;
                        r_phase     <= PH_LOW;
                    end
                end
                PH_LOW: begin
                    if (w_div_end) begin
                        spi_sclk <= 1'b1;
                        rx_bit   <= spi_miso;
                        bit_done <= 1'b1;
                        r_div    <= '0;
                        r_phase  <= PH_HIGH;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (w_div_end) begin
                        spi_sclk <= 1'b0;
                        r_div    <= '0;
                        if (r_bits_left == CNT_W'(1)) begin
                            spi_mosi <= 1'b0;
                            r_phase  <= PH_TAIL;
                        end else begin
                            // Next bit is presented on the same edge SCK falls.
                            spi_mosi    <= r_shreg[30];
                            r_shreg     <= {r_shreg[29:0], 1'b0};
                            r_bits_left <= r_bits_left - 1'b1;
                            r_phase     <= PH_LOW;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                PH_TAIL: begin
                    // Hold SCK low a full half-period so CS can rise cleanly.
                    if (w_div_end) begin
                        xfer_done <= 1'b1;
                        r_div     <= '0;
                        r_phase   <= PH_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : Wakes an SPI flash and streams ROM_SIZE 16-bit words out of it.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int          ROM_SIZE     = 8,
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int          CLK_DIV      = 1,
    parameter int          WAKE_CYCLES  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              spi_cs,
    output logic                              spi_sclk,
    output logic                              spi_mosi,
    input  logic                              spi_miso,
    output logic                              wr_en,
    output logic [addr_width(ROM_SIZE)-1:0]   wr_addr,
    output logic [15:0]                       wr_data,
    output logic                              done
);

    localparam int ADDR_W = addr_width(ROM_SIZE);
    localparam int WCNT_W = $clog2(ROM_SIZE) + 1;
    localparam int CNT_W  = $clog2(read_bits(ROM_SIZE) + 1);
    localparam int GAP_W  = $clog2(WAKE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  C_WAKE_BITS = CNT_W'(WAKE_BITS);
    localparam logic [CNT_W-1:0]  C_READ_BITS = CNT_W'(read_bits(ROM_SIZE));
    localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(WAKE_CYCLES - 1);
    localparam logic [WCNT_W-1:0] C_WORDS     = WCNT_W'(ROM_SIZE);

    logic [1:0]        r_rst_sync;
    logic              w_run;
    logic [2:0]        r_state;
    logic              r_armed;
    logic              r_start;
    logic [CNT_W-1:0]  r_nbits;
    logic [31:0]       r_tx_data;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [4:0]        r_bit_cnt;
    logic [14:0]       r_shift;
    logic [WCNT_W-1:0] r_word_cnt;

    logic w_busy;
    logic w_bit_done;
    logic w_rx_bit;
    logic w_xfer_done;

    // Reset asserts asynchronously but the sequencer only runs once the
    // release has passed through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (r_start),
        .nbits     (r_nbits),
        .tx_data   (r_tx_data),
        .spi_miso  (spi_miso),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .busy      (w_busy),
        .bit_done  (w_bit_done),
        .rx_bit    (w_rx_bit),
        .xfer_done (w_xfer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAKE_CMD;
            r_armed    <= 1'b0;
            r_start    <= 1'b0;
            r_nbits    <= '0;
            r_tx_data  <= '0;
            r_gap_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_word_cnt <= '0;
            spi_cs     <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
        end else if (w_run) begin
            r_start <= 1'b0;
            wr_en   <= 1'b0;
            if (wr_en && (r_word_cnt == C_WORDS)) begin
                done <= 1'b1;
            end
            case (r_state)
                ST_WAKE_CMD: begin
                    if (!r_armed) begin
                        if (!w_busy) begin
                            spi_cs    <= 1'b0;
                            r_start   <= 1'b1;
                            r_nbits   <= C_WAKE_BITS;
                            r_tx_data <= {CMD_WAKE, 24'h000000};
                            r_armed   <= 1'b1;
                        end
                    end else if (w_xfer_done) begin
                        spi_cs    <= 1'b1;
                        r_armed   <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_WAKE_GAP;
                    end
                end
                ST_WAKE_GAP: begin
                    // CS drops on the gap's last edge so it is high exactly WAKE_CYCLES.
                    if (r_gap_cnt == C_GAP_LAST) begin
                        spi_cs    <= 1'b0;
                        r_start   <= 1'b1;
                        r_nbits   <= C_READ_BITS;
                        r_tx_data <= {CMD_READ, FLASH_OFFSET};
                        r_bit_cnt <= '0;
                        r_state   <= ST_READ_CMD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_READ_CMD: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == 5'd31) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_READ_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (w_bit_done) begin
                        r_shift   <= {r_shift[13:0], w_rx_bit};
                        r_bit_cnt <= {1'b0, r_bit_cnt[3:0] + 4'd1};
                        if (r_bit_cnt[3:0] == 4'd15) begin
                            wr_en      <= 1'b1;
                            wr_data    <= {r_shift, w_rx_bit};
                            wr_addr    <= r_word_cnt[ADDR_W-1:0];
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                    if (w_xfer_done) begin
                        spi_cs  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    spi_cs <= 1'b1;
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_reader
// Description : Three loader configurations against a behavioural SPI flash.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    localparam int WAKE = 64;
    localparam int OFFS = 24'h100000;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic        rand_en;
    logic [2:0]  rand_bits;
    logic [15:0] words [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int ROM = (k == 2) ? 1 : 8;
        localparam int DIV = (k == 0) ? 1 : ((k == 1) ? 3 : 2);
        localparam int AW  = (ROM > 1) ? $clog2(ROM) : 1;

        logic          cs, sclk, mosi, miso, wr_en, done;
        logic [AW-1:0] wr_addr;
        logic [15:0]   wr_data;

        spi_flash_reader #(
            .ROM_SIZE     (ROM),
            .FLASH_OFFSET (24'h100000),
            .CLK_DIV      (DIV),
            .WAKE_CYCLES  (WAKE)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[k]),
            .spi_cs   (cs),
            .spi_sclk (sclk),
            .spi_mosi (mosi),
            .spi_miso (miso),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .done     (done)
        );

        // Behavioural mode-0 flash: big-endian words starting at OFFS
        int          fbits = 0;
        logic [31:0] fcmd  = '0;
        logic        woken = 1'b0;
        logic        fmiso = 1'b0;
        int          widx, bpos;
        logic [15:0] wval;

        assign miso = rand_en ? rand_bits[k] : fmiso;

        always @(negedge cs) begin fbits = 0; fcmd = '0; end
        always @(posedge cs) begin fbits = 0; fmiso = 1'b0; end

        always @(posedge sclk) begin
            if (!cs) begin
                if (fbits < 32) fcmd = {fcmd[30:0], mosi};
                fbits = fbits + 1;
                if (fbits == 8 && fcmd[7:0] == 8'hAB) woken = 1'b1;
            end
        end

        always @(negedge sclk) begin
            if (!cs && woken && fbits >= 32 && fcmd[31:24] == 8'h03) begin
                widx = (int'(fcmd[23:0]) - OFFS) / 2 + (fbits - 32) / 16;
                bpos = 15 - ((fbits - 32) % 16);
                if (widx >= 0 && widx < ROM) begin
                    wval  = (ROM == 1) ? 16'h8001 : words[widx[2:0]];
                    fmiso = wval[bpos[3:0]];
                end else begin
                    fmiso = 1'b0;
                end
            end
        end

        // Monitor: expected write stream plus SPI timing rules
        int          exp_idx = 0, win = 0, run = 0, rel = 0, cs_high_run = 0, wbits = 0;
        logic [31:0] wword = '0;
        logic [15:0] first_data = '0;
        logic        first_rise = 1'b0, settled = 1'b0;
        logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
        logic        prev_wr_en = 1'b0, prev_done = 1'b0;
        logic        s_rise, s_fall, c_rise, c_fall;

        always @(negedge clk) begin
            if (!rst_n[k]) begin
                chk($sformatf("i%0d reset_outputs", k),
                    {cs, sclk, mosi, wr_en, done, (wr_addr != '0), (wr_data != 16'h0)}, 7'b1000000);
                exp_idx = 0; win = 0; run = 0; rel = 0; cs_high_run = 0; wbits = 0;
                settled = 1'b0; first_rise = 1'b0;
                prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
                prev_wr_en = 1'b0; prev_done = 1'b0;
            end else begin
                rel++;
                s_rise = sclk && !prev_sclk;
                s_fall = !sclk && prev_sclk;
                c_rise = cs && !prev_cs;
                c_fall = !cs && prev_cs;

                if (wr_en) begin
                    chk($sformatf("i%0d wr_count", k), exp_idx < ROM, 1);
                    chk($sformatf("i%0d wr_addr", k), 32'(wr_addr), exp_idx);
                    chk($sformatf("i%0d wr_data", k), wr_data,
                        (ROM == 1) ? 16'h8001 : words[exp_idx[2:0]]);
                    chk($sformatf("i%0d wr_pulse", k), prev_wr_en, 0);
                    if (exp_idx == 0) first_data = wr_data;
                    exp_idx++;
                end
                if (done && !prev_done)
                    chk($sformatf("i%0d done_after_last_wr", k), {prev_wr_en, exp_idx == ROM}, 2'b11);
                if (prev_done)
                    chk($sformatf("i%0d done_held", k), done, 1);
                if (mosi !== prev_mosi)
                    chk($sformatf("i%0d mosi_when_sclk_low", k), sclk, 0);

                if (c_fall) begin
                    if (win == 0) chk($sformatf("i%0d cs_after_release", k), rel >= 3, 1);
                    if (win == 1) chk($sformatf("i%0d wake_gap_len", k), cs_high_run, WAKE);
                    win++; wbits = 0; wword = '0; first_rise = 1'b1;
                end
                if (c_rise) begin
                    chk($sformatf("i%0d cs_rise_sclk_low", k), sclk, 0);
                    chk($sformatf("i%0d cs_lag", k), run >= DIV, 1);
                    if (win == 1)
                        chk($sformatf("i%0d wake_cmd", k), (wbits << 8) | int'(wword[7:0]), (8 << 8) | 8'hAB);
                    if (win == 2)
                        chk($sformatf("i%0d read_window_bits", k), wbits, 32 + 16 * ROM);
                end
                if (s_rise) begin
                    chk($sformatf("i%0d sclk_needs_cs", k), cs, 0);
                    if (first_rise) chk($sformatf("i%0d cs_lead", k), run >= DIV, 1);
                    else            chk($sformatf("i%0d sck_low", k), run, DIV);
                    first_rise = 1'b0;
                    if (wbits < 32) wword = {wword[30:0], mosi};
                    wbits++;
                    if (win == 2 && wbits == 32)
                        chk($sformatf("i%0d read_cmd_addr", k), wword, 32'h03100000);
                end
                if (s_fall) chk($sformatf("i%0d sck_high", k), run, DIV);

                if (settled)
                    chk($sformatf("i%0d done_static", k), {cs, sclk, mosi, wr_en, done}, 5'b10001);
                if (done && cs) settled = 1'b1;

                if (s_rise || s_fall || c_rise || c_fall) run = 1;
                else run++;
                if (c_rise) cs_high_run = 1;
                else if (cs) cs_high_run++;

                prev_cs = cs; prev_sclk = sclk; prev_mosi = mosi;
                prev_wr_en = wr_en; prev_done = done;
            end
        end
    end

    initial begin
        int n;
        rst_n     = 3'b000;
        rand_en   = 1'b0;
        rand_bits = 3'b000;
        words[0]  = 16'h1234;
        words[1]  = 16'hABCD;
        for (int i = 2; i < 8; i++) words[i] = 16'($urandom);

        repeat (4) @(posedge clk);
        #2 rst_n = 3'b111;

        n = 0;
        while (g_inst[0].exp_idx < 4 && n < 5000) begin @(posedge clk); n++; end
        chk("i0 reach_word4", g_inst[0].exp_idx >= 4, 1);

        // Abort instance 0 in the middle of word 4, off the clock edge
        repeat (10) @(posedge clk);
        #3 rst_n[0] = 1'b0;
        #1 chk("i0 abort_immediate", {g_inst[0].cs, g_inst[0].sclk, g_inst[0].mosi, g_inst[0].wr_en}, 4'b1000);
        repeat (3) @(posedge clk);
        #2 rst_n[0] = 1'b1;

        n = 0;
        while (!(g_inst[0].settled && g_inst[1].settled && g_inst[2].settled) && n < 20000) begin
            @(posedge clk); n++;
        end
        chk("all_done", {g_inst[0].settled, g_inst[1].settled, g_inst[2].settled}, 3'b111);

        chk("i0 first_word", g_inst[0].first_data, 16'h1234);
        chk("i1 first_word", g_inst[1].first_data, 16'h1234);
        chk("i2 only_word", g_inst[2].wr_data, 16'h8001);
        chk("i0 last_addr", 32'(g_inst[0].wr_addr), 7);
        chk("i1 last_data", g_inst[1].wr_data, words[7]);
        chk("i2 last_addr", 32'(g_inst[2].wr_addr), 0);

        rand_en = 1'b1;
        repeat (1000) begin
            @(posedge clk);
            #2 rand_bits = 3'($urandom);
        end
        chk("wr_totals", {8'(g_inst[0].exp_idx), 8'(g_inst[1].exp_idx), 8'(g_inst[2].exp_idx)},
            {8'd8, 8'd8, 8'd1});
        chk("done_final", {g_inst[0].done, g_inst[1].done, g_inst[2].done}, 3'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter ROM_SIZE, default 8, number of 16-bit words to load.
REQ-002 Parameter FLASH_OFFSET, default 24'h100000, flash byte address of word 0.
REQ-003 Parameter CLK_DIV, default 1, clk cycles per SCK half-period (>=1).
REQ-004 Parameter WAKE_CYCLES, default 64, clk cycles CS held high after wake command.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 spi_cs  output  1  flash chip select, active-low.
REQ-008 spi_sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 spi_mosi  output  1  command/address bits to flash.
REQ-010 spi_miso  input  1  data from flash.
REQ-011 wr_en  output  1  one-cycle pulse: wr_data valid for wr_addr.
REQ-012 wr_addr  output  clog2(ROM_SIZE)  word index being written.
REQ-013 wr_data  output  16  assembled word, first received bit = bit 15.
REQ-014 done  output  1  high once all ROM_SIZE words written; held until reset.

Function
REQ-015 States: WAKE_CMD, WAKE_GAP, READ_CMD, READ_DATA, DONE; after reset release, first state WAKE_CMD.
REQ-016 WAKE_CMD: spi_cs low, shift 8'hAB MSB first, then spi_cs high, enter WAKE_GAP.
REQ-017 WAKE_GAP: spi_cs high, spi_sclk low, exactly WAKE_CYCLES clk cycles, then READ_CMD.
REQ-018 READ_CMD: spi_cs low, shift 32 bits {8'h03, FLASH_OFFSET} MSB first, then READ_DATA without raising spi_cs.
REQ-019 SCK: toggles every CLK_DIV clk cycles while shifting; spi_mosi changes only while spi_sclk low; spi_miso sampled on the clk cycle spi_sclk rises.
REQ-020 spi_cs falls at least one SCK half-period before first rising edge; rises only with spi_sclk low, at least one half-period after last falling edge.
REQ-021 READ_DATA: 16*ROM_SIZE rising edges; every 16th sample completes a word.
REQ-022 wr_en pulses the clk cycle after the 16th bit of a word is sampled; wr_addr = 0,1,...,ROM_SIZE-1 in order; wr_data/wr_addr stable during pulse.
REQ-023 Exactly ROM_SIZE wr_en pulses per reset; no pulse outside READ_DATA.
REQ-024 After final word: spi_cs high, spi_sclk low, spi_mosi low, enter DONE; done rises the cycle after final wr_en.
REQ-025 DONE is terminal; outputs static, spi_miso ignored.
REQ-026 spi_mosi low whenever not shifting a command/address bit.
REQ-027 Word counter sized clog2(ROM_SIZE)+1 to detect completion without wrap; ROM_SIZE=1 supported (wr_addr width 1).

Reset
REQ-028 rst_n low asserts immediately, regardless of clk: spi_cs=1, spi_sclk=0, spi_mosi=0, wr_en=0, wr_addr=0, wr_data=0, done=0, state=WAKE_CMD, counters 0.
REQ-029 Reset mid-transfer aborts it (spi_cs high at once); full wake+read sequence restarts after release.
REQ-030 rst_n release synchronized internally; first spi_cs fall no earlier than two clk cycles after release.

Structure
REQ-031 Package spi_flash_pkg holds opcodes (CMD_READ=8'h03, CMD_WAKE=8'hAB), state encoding, command length constants.
REQ-032 Sub-module spi_bit_engine: SCK divider plus 32-bit MSB-first shifter/sampler with start/busy/bit-done handshake; FSM in spi_flash_reader sequences it.

Verification
REQ-033 Flash model (mode 0, responds to 0xAB and 0x03+addr) preloaded words 16'h1234,16'hABCD,... ROM_SIZE=8 -> 8 wr_en pulses, addr 0..7, data match, done=1.
REQ-034 Monitor MOSI during first CS-low window -> exactly 8 bits 0xAB; CS high for >=64 clk; next window begins 32 bits 0x03_100000.
REQ-035 CLK_DIV=3 -> SCK high and low each exactly 3 clk; loaded data identical to REQ-033.
REQ-036 rst_n low during word 4 of READ_DATA -> CS high same cycle, no further wr_en; after release, sequence restarts at wr_addr 0, completes with correct data.
REQ-037 ROM_SIZE=1, word 16'h8001 -> single wr_en, wr_addr=0, wr_data=16'h8001, done=1, CS high thereafter.
REQ-038 After done, toggle spi_miso randomly 1000 cycles -> no wr_en, CS stays high, SCK stays low.
